// File: rtl/cirno_pkg.sv
// Shared types and defaults for the cirno core front end.
package cirno_pkg;

  localparam int PC_WIDTH   = 8;
  localparam int INST_WIDTH = 9;
  localparam int RESET_PC   = 0;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DEC  = 3'd3,
    EXEC = 3'd4,
    HALT = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for a retiring instruction: halt, absolute branch,
// PC-relative branch or sequential advance, in that priority.
module pc_next_calc #(
  parameter int PC_WIDTH = cirno_pkg::PC_WIDTH
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                branch,
  input  logic                branchi,
  input  logic                done,
  input  logic [5:0]          immediate,
  input  logic [PC_WIDTH-1:0] reg_target,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                halt
);

  function automatic logic signed [PC_WIDTH-1:0] sext_imm(input logic signed [5:0] imm);
    return {{(PC_WIDTH-6){imm[5]}}, imm};
  endfunction

  logic signed [PC_WIDTH-1:0] imm_ext;

  always_comb begin
    imm_ext = sext_imm(immediate);
    halt    = done;
    // Additions are modulo 2^PC_WIDTH by construction of the result width.
    if (done) begin
      pc_next = pc;
    end else if (branch) begin
      pc_next = reg_target;
    end else if (branchi) begin
      pc_next = pc + $unsigned(imm_ext);
    end else begin
      pc_next = pc + PC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch/sequencer for the cirno core: fetches one
// word, strobes the decoder, waits for execute, then picks the next PC.
module fetch_unit
  import cirno_pkg::*;
#(
  parameter int PC_WIDTH   = cirno_pkg::PC_WIDTH,
  parameter int INST_WIDTH = cirno_pkg::INST_WIDTH,
  parameter int RESET_PC   = cirno_pkg::RESET_PC,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_valid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  decoder_en,
  input  logic                  exec_done,
  input  logic                  branch,
  input  logic                  branchi,
  input  logic [5:0]            immediate,
  input  logic                  done,
  input  logic [PC_WIDTH-1:0]   reg_target,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  busy,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  retired
);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
    return (&val) ? val : val + CNT_WIDTH'(1);
  endfunction

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;

  logic [PC_WIDTH-1:0]   pc_next;
  logic                  halt_next;

  pc_next_calc #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_next_calc (
    .pc         (pc_q),
    .branch     (branch),
    .branchi    (branchi),
    .done       (done),
    .immediate  (immediate),
    .reg_target (reg_target),
    .pc_next    (pc_next),
    .halt       (halt_next)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d   = REQ;
          pc_d      = PC_WIDTH'(RESET_PC);
          retired_d = '0;
        end
      end
      REQ:  state_d = WAIT;
      WAIT: begin
        if (imem_valid) begin
          inst_d  = imem_rdata;
          state_d = DEC;
        end
      end
      DEC:  state_d = EXEC;
      EXEC: begin
        // Decoder outputs are only trusted on the exec_done cycle.
        if (exec_done) begin
          retired_d = sat_inc(retired_q);
          pc_d      = pc_next;
          state_d   = halt_next ? HALT : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= PC_WIDTH'(RESET_PC);
      inst_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
    end
  end

  assign imem_req   = (state_q == REQ);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign decoder_en = (state_q == DEC);
  assign halted     = (state_q == HALT);
  assign busy       = (state_q != IDLE) && (state_q != HALT);
  assign retired    = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, hand-written corner sequences and
// random instruction streams checked against a PC/retire-count model.
module tb_fetch_unit;

  localparam int PCW     = 8;
  localparam int IW      = 9;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic           clk;
  logic           reset;
  logic           start;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_valid;
  logic [IW-1:0]  imem_rdata;
  logic [IW-1:0]  inst;
  logic           decoder_en;
  logic           exec_done;
  logic           branch;
  logic           branchi;
  logic [5:0]     immediate;
  logic           done;
  logic [PCW-1:0] reg_target;
  logic [PCW-1:0] pc;
  logic           busy;
  logic           halted;
  logic [CW-1:0]  retired;

  fetch_unit #(
    .PC_WIDTH(PCW), .INST_WIDTH(IW), .RESET_PC(0), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .inst(inst), .decoder_en(decoder_en), .exec_done(exec_done),
    .branch(branch), .branchi(branchi), .immediate(immediate), .done(done),
    .reg_target(reg_target), .pc(pc), .busy(busy), .halted(halted),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             lat;
    int             ew;
    bit             br;
    bit             bri;
    logic [5:0]     imm;
    bit             dn;
    logic [PCW-1:0] tgt;
    logic [IW-1:0]  word;
    logic [PCW-1:0] addr;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int m_pc   = 0;
  int m_ret  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_next(input int cur, input vec_t v);
    int off;
    if (v.dn)  return cur;
    if (v.br)  return int'(v.tgt);
    if (v.bri) begin
      off = v.imm[5] ? int'(v.imm) - 64 : int'(v.imm);
      return (cur + off + 256) % 256;
    end
    return (cur + 1) % 256;
  endfunction

  task automatic clear_inputs();
    start = 0; imem_valid = 0; imem_rdata = '0; exec_done = 0;
    branch = 0; branchi = 0; immediate = '0; done = 0; reg_target = '0;
  endtask

  // Entered with REQ visible; leaves with REQ (or HALT) visible.
  task automatic run_instr(input vec_t v);
    chk("req_asserted", imem_req, 1);
    chk("fetch_addr", imem_addr, v.addr);
    chk("pc_out", pc, v.addr);
    chk("busy_req", busy, 1);
    step();
    for (int i = 0; i < v.lat - 1; i++) begin
      imem_valid = 0;
      exec_done  = 1'($urandom);
      start      = 1'($urandom);
      chk("wait_no_req", imem_req, 0);
      chk("wait_no_dec", decoder_en, 0);
      step();
    end
    imem_valid = 1; imem_rdata = v.word; exec_done = 0; start = 0;
    chk("wait_busy", busy, 1);
    step();
    imem_valid = 0;
    chk("dec_strobe", decoder_en, 1);
    chk("inst_latched", inst, v.word);
    chk("dec_no_req", imem_req, 0);
    step();
    chk("dec_one_cycle", decoder_en, 0);
    for (int i = 0; i < v.ew; i++) begin
      start      = 1'($urandom);
      imem_valid = 1'($urandom);
      branch     = 1'($urandom);
      done       = 1'($urandom);
      branchi    = 1'($urandom);
      chk("exec_no_req", imem_req, 0);
      chk("exec_busy", busy, 1);
      step();
    end
    start = 0; imem_valid = 0;
    exec_done = 1; branch = v.br; branchi = v.bri; immediate = v.imm;
    done = v.dn; reg_target = v.tgt;
    step();
    clear_inputs();
    m_ret = (m_ret < CNT_MAX) ? m_ret + 1 : CNT_MAX;
    m_pc  = model_next(m_pc, v);
    chk("retired", retired, m_ret);
    chk("pc_after", pc, m_pc);
    if (v.dn) begin
      chk("halted", halted, 1);
      chk("halt_not_busy", busy, 0);
      chk("halt_no_req", imem_req, 0);
    end
  endtask

  task automatic do_start();
    start = 1;
    step();
    start = 0;
    m_pc = 0; m_ret = 0;
    chk("start_retired_clr", retired, 0);
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    clear_inputs();
    reset = 1;
    step(); step();
    chk("rst_pc", pc, 0);
    chk("rst_inst", inst, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_dec", decoder_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
    reset = 0;
    step();
    chk("idle_stays", busy, 0);

    //           lat ew br bri imm        dn tgt    word    addr
    tbl[0]  = '{1, 0, 0, 0, 6'b000000, 0, 8'h00, 9'h000, 8'h00};
    tbl[1]  = '{5, 0, 0, 0, 6'b000000, 0, 8'h00, 9'h000, 8'h01};
    tbl[2]  = '{1, 0, 1, 0, 6'b000000, 0, 8'h10, 9'h000, 8'h02};
    tbl[3]  = '{2, 10, 0, 1, 6'b111110, 0, 8'h00, 9'h0FF, 8'h10};
    tbl[4]  = '{1, 0, 1, 0, 6'b000000, 0, 8'h10, 9'h100, 8'h0E};
    tbl[5]  = '{3, 1, 0, 1, 6'b000011, 0, 8'h00, 9'h055, 8'h10};
    tbl[6]  = '{1, 0, 1, 0, 6'b000000, 0, 8'hFF, 9'h1FF, 8'h13};
    tbl[7]  = '{1, 0, 0, 0, 6'b000000, 0, 8'h00, 9'h0AA, 8'hFF};
    tbl[8]  = '{1, 2, 0, 1, 6'b100000, 0, 8'h00, 9'h123, 8'h00};
    tbl[9]  = '{1, 0, 1, 1, 6'b000001, 0, 8'h40, 9'h04F, 8'hE0};
    tbl[10] = '{4, 0, 0, 1, 6'b011111, 0, 8'h00, 9'h111, 8'h40};
    tbl[11] = '{1, 0, 1, 0, 6'b000000, 1, 8'h22, 9'h1EE, 8'h5F};

    do_start();
    for (int i = 0; i < 12; i++) run_instr(tbl[i]);

    // Parked in HALT: memory/execute noise must not wake it.
    for (int i = 0; i < 3; i++) begin
      imem_valid = 1'($urandom); exec_done = 1'($urandom);
      step();
      chk("halt_idle_req", imem_req, 0);
      chk("halt_stays", halted, 1);
      chk("halt_pc", pc, 8'h5F);
    end
    clear_inputs();
    do_start();
    chk("restart_addr", imem_addr, 0);

    // Reset while waiting on memory.
    v = '{1, 0, 0, 0, 6'd0, 0, 8'h00, 9'h000, 8'h00};
    v.addr = 8'(m_pc); run_instr(v);
    v.addr = 8'(m_pc); run_instr(v);
    step();
    reset = 1;
    step();
    reset = 0;
    chk("rstw_busy", busy, 0);
    chk("rstw_halted", halted, 0);
    chk("rstw_pc", pc, 0);
    chk("rstw_retired", retired, 0);
    chk("rstw_req", imem_req, 0);
    for (int i = 0; i < 3; i++) begin
      imem_valid = 1; imem_rdata = 9'h1C3;
      step();
      chk("rstw_no_dec", decoder_en, 0);
      chk("rstw_idle", busy, 0);
      chk("rstw_inst", inst, 0);
    end
    clear_inputs();

    // exec_done coinciding with reset must not retire.
    do_start();
    step();
    imem_valid = 1; step();
    imem_valid = 0; step();
    exec_done = 1; reset = 1;
    step();
    reset = 0; clear_inputs();
    chk("edrst_retired", retired, 0);
    chk("edrst_busy", busy, 0);
    chk("edrst_pc", pc, 0);

    // Random instruction streams.
    do_start();
    for (int n = 0; n < 80; n++) begin
      v.lat  = int'($urandom_range(1, 4));
      v.ew   = int'($urandom_range(0, 3));
      v.br   = ($urandom_range(0, 5) == 0);
      v.bri  = ($urandom_range(0, 2) == 0);
      v.imm  = 6'($urandom);
      v.dn   = ($urandom_range(0, 19) == 0);
      v.tgt  = 8'($urandom);
      v.word = 9'($urandom);
      v.addr = 8'(m_pc);
      run_instr(v);
      if (v.dn) begin
        step();
        do_start();
      end
    end

    // Retirement counter saturation.
    reset = 1; step(); reset = 0;
    do_start();
    v = '{1, 0, 0, 0, 6'd0, 0, 8'h00, 9'h000, 8'h00};
    for (int n = 0; n < CNT_MAX + 3; n++) begin
      v.addr = 8'(m_pc);
      run_instr(v);
    end
    chk("retired_saturated", retired, CNT_MAX);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch and sequencing stage for the cirno core, directly upstream of the decoder.
- Owns the PC and issues one-word reads to instruction memory.
- Latches the 9-bit instruction word and pulses decoder_en for exactly one cycle.
- Waits for the execute stage to finish, then selects the next PC from the decoder's branch/branchi/done outputs.
- Strictly non-pipelined: one instruction in flight.

Parameters:
- PC_WIDTH, 8, width of PC and instruction-memory address; PC arithmetic wraps modulo 2^PC_WIDTH.
- INST_WIDTH, 9, instruction word width.
- RESET_PC, 0, PC loaded on reset and on start.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin execution at RESET_PC; honoured only in IDLE or HALT.
- imem_req  out  1  one-cycle read request to instruction memory.
- imem_addr  out  PC_WIDTH  read address; always equals pc.
- imem_valid  in  1  read data valid; sampled only in WAIT.
- imem_rdata  in  INST_WIDTH  instruction word.
- inst  out  INST_WIDTH  latched instruction to the decoder.
- decoder_en  out  1  one-cycle decode strobe.
- exec_done  in  1  execute stage finished the current instruction; sampled only in EXEC.
- branch  in  1  from decoder: absolute jump to reg_target.
- branchi  in  1  from decoder: PC-relative jump by immediate.
- immediate  in  6  from decoder: signed offset for branchi.
- done  in  1  from decoder: halt instruction.
- reg_target  in  PC_WIDTH  register-file value read for branch.
- pc  out  PC_WIDTH  current PC.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- retired  out  CNT_WIDTH  count of retired instructions, saturating.

Behaviour:
- Reset: state=IDLE, pc=RESET_PC, inst=0, imem_req=0, decoder_en=0, busy=0, halted=0, retired=0. Reset takes priority over every other input in every state; mid-operation it abandons any in-flight read or execution.
- IDLE: start -> REQ (pc=RESET_PC, retired=0). Otherwise stay.
- REQ: imem_req=1 for exactly this cycle, imem_addr=pc -> WAIT unconditionally.
- WAIT: imem_valid=1 -> inst<=imem_rdata, go to DEC. Otherwise stay; no timeout. Memory latency is ≥1 cycle after REQ; imem_valid in any other state is ignored.
- DEC: decoder_en=1 for exactly this cycle -> EXEC. The decoder's registered outputs are valid from the first EXEC cycle.
- EXEC: wait for exec_done=1. On that cycle, sample done/branch/branchi/immediate/reg_target and retire the instruction (retired+1, saturates at all-ones). Then resolve in priority order:
  1. done=1 -> HALT; pc unchanged.
  2. branch=1 -> pc=reg_target, go to REQ.
  3. branchi=1 -> pc=pc+sign_extend(immediate), go to REQ.
  4. else -> pc=pc+1, go to REQ.
- Wrap-around: pc=2^PC_WIDTH-1 with a sequential advance gives 0; branchi offsets also wrap. Branch inputs are ignored outside the exec_done cycle.
- HALT: halted=1, busy=0. start -> REQ with pc=RESET_PC and retired=0. Otherwise stay.
- Fixed latencies:
  - Minimum instruction period: REQ + WAIT(1) + DEC + EXEC(1) = 4 cycles.
  - decoder_en asserts exactly 1 cycle after imem_valid is accepted.
- Simultaneous events:
  - start in busy states is ignored.
  - exec_done together with reset: reset wins, and the instruction is not counted.

Decomposition:
- Package cirno_pkg holds:
  - fetch state enum {IDLE, REQ, WAIT, DEC, EXEC, HALT};
  - INST_WIDTH and PC_WIDTH constants;
  - RESET_PC default.
- One natural sub-module, pc_next_calc: a purely combinational priority select of pc+1, pc+sext(imm), or reg_target, plus a halt flag. Instantiated once in fetch_unit.

Test Plan:
- Reset then start, memory latency 1, words 0x000 at addresses 0..2, exec_done on the first EXEC cycle -> imem_addr 0,1,2 in that order; 4 cycles per instruction; decoder_en one cycle each; retired=3 after the third instruction.
- Memory latency 5 cycles -> stays in WAIT for 5 cycles; decoder_en asserts exactly one cycle after imem_valid; inst equals imem_rdata.
- At pc=0x10: branchi with immediate=6'b111110 (-2) -> next fetch address 0x0E. With immediate=6'b000011 -> 0x13. At pc=0xFF, sequential advance -> 0x00.
- branch=1 and branchi=1 together with reg_target=0x40 -> next address 0x40. done=1 together with branch=1 -> HALT, halted=1, pc unchanged, no further imem_req.
- exec_done held low for 10 cycles -> remains in EXEC, no imem_req, start ignored. Reset asserted during WAIT -> next cycle state IDLE, pc=RESET_PC, retired=0, later imem_valid ignored.
- From HALT, start -> fetch resumes at RESET_PC with retired cleared. Drive 0xFFFF+2 retirements with CNT_WIDTH=16 -> retired saturates at 0xFFFF.
